// File: rtl/store_buf_pkg.sv
// Shared types for the posted store write buffer: the buffered entry layout and
// the drain FSM states.
package store_buf_pkg;

    // Byte-address width the entry layout is built for; the top ADDR_W must match.
    localparam int unsigned SB_ADDR_W = 32;

    typedef struct packed {
        logic [SB_ADDR_W-3:0] addr;
        logic [31:0]          wdata;
        logic [3:0]           bmask;
    } sb_entry_t;

    typedef enum logic [0:0] {
        SB_IDLE,
        SB_REQ
    } sb_state_e;

endpackage

// File: rtl/sb_fifo.sv
// Entry storage for the store write buffer: circular array with per-entry valid
// bits, head/tail pointers and an occupancy count used for full/empty.
module sb_fifo
    import store_buf_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  sb_entry_t            push_entry_i,
    input  logic                 pop_i,
    output sb_entry_t            head_o,
    output logic [DEPTH-1:0]     valid_o,
    output logic [SB_ADDR_W-3:0] addr_o [DEPTH],
    output logic [CNT_W-1:0]     count_o,
    output logic [CNT_W-1:0]     count_next_o
);

    sb_entry_t          mem_q [DEPTH];
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop_i) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (push_i) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: valid bits and the drain FSM gate every consumer.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[tail_q] <= push_entry_i;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            addr_o[i] = mem_q[i].addr;
        end
    end

    assign head_o       = mem_q[head_q];
    assign valid_o      = valid_q;
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/store_write_buffer.sv
// Posted-write buffer: queues store beats, drains them in order over a req/ack
// memory handshake, and flags loads hitting a word still held in the buffer.
module store_write_buffer
    import store_buf_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = SB_ADDR_W
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_st_valid,
    input  logic [ADDR_W-1:0]          i_st_addr,
    input  logic [31:0]                i_st_wdata,
    input  logic [3:0]                 i_st_bmask,
    output logic                       o_st_ready,
    input  logic                       i_ld_valid,
    input  logic [ADDR_W-1:0]          i_ld_addr,
    output logic                       o_ld_hazard,
    output logic                       o_mem_req,
    output logic [ADDR_W-1:0]          o_mem_addr,
    output logic [31:0]                o_mem_wdata,
    output logic [3:0]                 o_mem_bmask,
    input  logic                       i_mem_ack,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    sb_state_e            state_q, state_d;
    sb_entry_t            push_entry;
    sb_entry_t            head;
    logic                 push, pop;
    logic [DEPTH-1:0]     valid;
    logic [ADDR_W-3:0]    entry_addr [DEPTH];
    logic [CNT_W-1:0]     count, count_next;

    // Zero-mask beats are accepted (ready is honoured) but never enqueued.
    assign push = i_st_valid && o_st_ready && (i_st_bmask != 4'b0000);
    assign pop  = o_mem_req && i_mem_ack;

    assign push_entry = '{addr: i_st_addr[ADDR_W-1:2], wdata: i_st_wdata, bmask: i_st_bmask};

    sb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (i_clk),
        .rst_ni       (i_rst_n),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .valid_o      (valid),
        .addr_o       (entry_addr),
        .count_o      (count),
        .count_next_o (count_next)
    );

    // Decide on the post-update count so a push into an empty buffer requests next cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SB_IDLE: if (count_next != '0) state_d = SB_REQ;
            SB_REQ:  if (pop && (count_next == '0)) state_d = SB_IDLE;
            default: state_d = SB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= SB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        o_mem_req   = (state_q == SB_REQ);
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_bmask = '0;
        if (o_mem_req) begin
            o_mem_addr  = {head.addr, 2'b00};
            o_mem_wdata = head.wdata;
            o_mem_bmask = head.bmask;
        end
    end

    always_comb begin
        o_ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (entry_addr[i] == i_ld_addr[ADDR_W-1:2])) begin
                o_ld_hazard = i_ld_valid;
            end
        end
    end

    assign o_count    = count;
    assign o_empty    = (count == '0);
    assign o_st_ready = (count < CNT_W'(DEPTH));

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed self-checking bench for store_write_buffer (DEPTH=4, ADDR_W=32).
module tb_store_write_buffer;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [3:0]  st_bmask;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_bmask;
    logic        mem_ack;
    logic        empty;
    logic [2:0]  count;

    int n_assert = 0;
    int n_fail   = 0;

    store_write_buffer #(
        .DEPTH  (4),
        .ADDR_W (32)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_st_valid  (st_valid),
        .i_st_addr   (st_addr),
        .i_st_wdata  (st_wdata),
        .i_st_bmask  (st_bmask),
        .o_st_ready  (st_ready),
        .i_ld_valid  (ld_valid),
        .i_ld_addr   (ld_addr),
        .o_ld_hazard (ld_hazard),
        .o_mem_req   (mem_req),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_mem_bmask (mem_bmask),
        .i_mem_ack   (mem_ack),
        .o_empty     (empty),
        .o_count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_wdata = '0;
        st_bmask = '0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        mem_ack  = 1'b0;
        repeat (2) tick();

        // Reset state
        ld_valid = 1'b1;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ready", 32'(st_ready), 32'd1);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_bmask", 32'(mem_bmask), 32'd0);
        chk("rst_hazard", 32'(ld_hazard), 32'd0);
        ld_valid = 1'b0;
        rst_n    = 1'b1;
        tick();

        // Single store
        st_valid = 1'b1;
        st_addr  = 32'h1002;
        st_wdata = 32'h00AB_0000;
        st_bmask = 4'b0100;
        tick();
        st_valid = 1'b0;
        chk("single_req", 32'(mem_req), 32'd1);
        chk("single_addr", mem_addr, 32'h1000);
        chk("single_wdata", mem_wdata, 32'h00AB_0000);
        chk("single_bmask", 32'(mem_bmask), 32'b0100);
        chk("single_count", 32'(count), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("single_empty", 32'(empty), 32'd1);
        chk("single_req_drop", 32'(mem_req), 32'd0);

        // Zero mask
        st_valid = 1'b1;
        st_addr  = 32'h3000;
        st_wdata = 32'hDEAD_BEEF;
        st_bmask = 4'b0000;
        #1;
        chk("zmask_ready", 32'(st_ready), 32'd1);
        tick();
        st_valid = 1'b0;
        chk("zmask_count", 32'(count), 32'd0);
        chk("zmask_req", 32'(mem_req), 32'd0);
        tick();
        chk("zmask_req_late", 32'(mem_req), 32'd0);

        // Fill with ack low, then try a fifth beat
        for (int i = 0; i < 4; i++) begin
            st_valid = 1'b1;
            st_addr  = 32'h100 + 32'(4 * i);
            st_wdata = 32'h1111_1111 * 32'(i + 1);
            st_bmask = 4'hF;
            tick();
        end
        chk("fill_count", 32'(count), 32'd4);
        chk("fill_ready", 32'(st_ready), 32'd0);
        st_addr  = 32'h500;
        st_wdata = 32'h5555_5555;
        tick();
        st_valid = 1'b0;
        chk("full_reject_count", 32'(count), 32'd4);

        // Drain with ack every other cycle
        for (int i = 0; i < 4; i++) begin
            chk("drain_addr", mem_addr, 32'h100 + 32'(4 * i));
            chk("drain_wdata", mem_wdata, 32'h1111_1111 * 32'(i + 1));
            tick();
            chk("drain_hold_req", 32'(mem_req), 32'd1);
            chk("drain_hold_addr", mem_addr, 32'h100 + 32'(4 * i));
            chk("drain_hold_wdata", mem_wdata, 32'h1111_1111 * 32'(i + 1));
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_req", 32'(mem_req), 32'd0);

        // Simultaneous push and pop at count=2
        st_valid = 1'b1;
        st_bmask = 4'hF;
        st_addr  = 32'h200;
        st_wdata = 32'hA0;
        tick();
        st_addr  = 32'h204;
        st_wdata = 32'hA1;
        tick();
        chk("sim_pre_count", 32'(count), 32'd2);
        st_addr  = 32'h208;
        st_wdata = 32'hA2;
        mem_ack  = 1'b1;
        tick();
        chk("sim_count", 32'(count), 32'd2);
        chk("sim_head", mem_addr, 32'h204);
        for (int i = 0; i < 3; i++) begin
            st_addr  = 32'h20C + 32'(4 * i);
            st_wdata = 32'hA3 + 32'(i);
            tick();
            chk("b2b_req", 32'(mem_req), 32'd1);
            chk("b2b_count", 32'(count), 32'd2);
            chk("b2b_head", mem_addr, 32'h208 + 32'(4 * i));
        end
        st_valid = 1'b0;
        tick();
        chk("b2b_tail_head", mem_addr, 32'h214);
        chk("b2b_tail_req", 32'(mem_req), 32'd1);
        tick();
        mem_ack = 1'b0;
        chk("b2b_done_req", 32'(mem_req), 32'd0);
        chk("b2b_done_empty", 32'(empty), 32'd1);

        // Hazard
        st_valid = 1'b1;
        st_addr  = 32'h2004;
        st_wdata = 32'h77;
        st_bmask = 4'b0001;
        ld_valid = 1'b1;
        ld_addr  = 32'h2004;
        #1;
        chk("haz_same_cycle_push", 32'(ld_hazard), 32'd0);
        tick();
        st_valid = 1'b0;
        ld_addr  = 32'h2007;
        #1;
        chk("haz_word_match", 32'(ld_hazard), 32'd1);
        ld_addr = 32'h2008;
        #1;
        chk("haz_next_word", 32'(ld_hazard), 32'd0);
        ld_valid = 1'b0;
        ld_addr  = 32'h2004;
        #1;
        chk("haz_ld_invalid", 32'(ld_hazard), 32'd0);
        ld_valid = 1'b1;
        mem_ack  = 1'b1;
        #1;
        chk("haz_in_flight_ack", 32'(ld_hazard), 32'd1);
        tick();
        mem_ack = 1'b0;
        chk("haz_after_pop", 32'(ld_hazard), 32'd0);
        ld_valid = 1'b0;

        // Reset mid-operation
        st_valid = 1'b1;
        st_bmask = 4'hF;
        for (int i = 0; i < 3; i++) begin
            st_addr  = 32'h400 + 32'(4 * i);
            st_wdata = 32'hC0 + 32'(i);
            tick();
        end
        st_valid = 1'b0;
        chk("mid_count", 32'(count), 32'd3);
        chk("mid_req", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_req", 32'(mem_req), 32'd0);
        tick();
        chk("post_rst_req2", 32'(mem_req), 32'd0);
        chk("post_rst_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
